// File: rtl/rcc_rsr_lsi_ctrl.sv
// rcc_rsr_lsi_ctrl: reset-status flags and LSI enable/ready control, VDD domain.
// Optional feature macro: RCC_LSI_TMO_EN adds an LSI ready timeout (FAIL state, lsi_fail port).
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | LSI disabled, oscillator enable low
// WAIT  | oscillator enabled, waiting for synchronised ready
// READY | oscillator running, ready reported
// FAIL  | ready did not arrive within LSI_TMO cycles (timeout build only)
module rcc_rsr_lsi_ctrl #(
  parameter int NUM_CPU = 2,
  parameter int NUM_SRC = 14,
  parameter logic [NUM_SRC-1:0] RST_FLAG_INIT = 14'h003E,
  parameter int LSI_TMO = 64
) (
  input  logic                       clk,
  input  logic                       pwr_por_rst,
  input  logic                       wdata,
  input  logic [NUM_CPU-1:0]         rmvf_wren,
  input  logic                       lsion_wren,
  input  logic [NUM_SRC-1:0]         rst_src,
  input  logic                       lsi_rdy,
  output logic [NUM_CPU*NUM_SRC-1:0] cur_rsr_flags,
  output logic [NUM_CPU-1:0]         cur_rsr_rmvf,
  output logic                       cur_csr_lsion,
  output logic                       cur_csr_lsirdy,
  output logic                       lsi_en
`ifdef RCC_LSI_TMO_EN
  ,
  output logic                       lsi_fail
`endif
);

  if (NUM_CPU < 1 || NUM_CPU > 4) begin : g_bad_num_cpu
    $error("rcc_rsr_lsi_ctrl: NUM_CPU must be 1..4");
  end
  if (LSI_TMO < 2) begin : g_bad_lsi_tmo
    $error("rcc_rsr_lsi_ctrl: LSI_TMO must be at least 2");
  end

  typedef enum logic [1:0] {
    LSI_OFF   = 2'd0,
    LSI_WAIT  = 2'd1,
    LSI_READY = 2'd2,
    LSI_FAIL  = 2'd3
  } lsi_state_e;

  logic [NUM_SRC-1:0] src_s1, src_s2, src_s3;
  logic [NUM_SRC-1:0] src_rise;
  logic               rdy_s1, rdy_s;
  lsi_state_e         state_q, state_nxt;

`ifdef RCC_LSI_TMO_EN
  localparam int CNT_W = $clog2(LSI_TMO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LSI_TMO - 1);
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             fail_nxt;
`endif

  // Reset-cause synchroniser plus edge flop; only rising edges are captured.
  always_ff @(posedge clk or posedge pwr_por_rst) begin
    if (pwr_por_rst) begin
      src_s1 <= '0;
      src_s2 <= '0;
      src_s3 <= '0;
    end else begin
      src_s1 <= rst_src;
      src_s2 <= src_s1;
      src_s3 <= src_s2;
    end
  end

  assign src_rise = src_s2 & ~src_s3;

  // Sticky per-CPU flags; an active RMVF clear wins over a same-cycle edge.
  always_ff @(posedge clk or posedge pwr_por_rst) begin
    if (pwr_por_rst) begin
      cur_rsr_flags <= {NUM_CPU{RST_FLAG_INIT}};
    end else begin
      for (int c = 0; c < NUM_CPU; c++) begin
        if (cur_rsr_rmvf[c]) begin
          cur_rsr_flags[c*NUM_SRC +: NUM_SRC] <= '0;
        end else begin
          cur_rsr_flags[c*NUM_SRC +: NUM_SRC] <= cur_rsr_flags[c*NUM_SRC +: NUM_SRC] | src_rise;
        end
      end
    end
  end

  // Software-written control bits: per-CPU RMVF and LSION.
  always_ff @(posedge clk or posedge pwr_por_rst) begin
    if (pwr_por_rst) begin
      cur_rsr_rmvf  <= '0;
      cur_csr_lsion <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CPU; c++) begin
        if (rmvf_wren[c]) begin
          cur_rsr_rmvf[c] <= wdata;
        end
      end
      if (lsion_wren) begin
        cur_csr_lsion <= wdata;
      end
    end
  end

  // LSI ready synchroniser.
  always_ff @(posedge clk or posedge pwr_por_rst) begin
    if (pwr_por_rst) begin
      rdy_s1 <= 1'b0;
      rdy_s  <= 1'b0;
    end else begin
      rdy_s1 <= lsi_rdy;
      rdy_s  <= rdy_s1;
    end
  end

  // LSI state register; enable and ready status are registered decodes of the next state.
  always_ff @(posedge clk or posedge pwr_por_rst) begin
    if (pwr_por_rst) begin
      state_q        <= LSI_OFF;
      lsi_en         <= 1'b0;
      cur_csr_lsirdy <= 1'b0;
`ifdef RCC_LSI_TMO_EN
      cnt_q          <= '0;
      lsi_fail       <= 1'b0;
`endif
    end else begin
      state_q        <= state_nxt;
      lsi_en         <= (state_nxt != LSI_OFF);
      cur_csr_lsirdy <= (state_nxt == LSI_READY);
`ifdef RCC_LSI_TMO_EN
      cnt_q          <= cnt_nxt;
      lsi_fail       <= fail_nxt;
`endif
    end
  end

  // LSI next-state logic; LSION low forces OFF from any state.
  always_comb begin
    state_nxt = state_q;
`ifdef RCC_LSI_TMO_EN
    cnt_nxt  = cnt_q;
    fail_nxt = lsi_fail;
`endif
    if (!cur_csr_lsion) begin
      state_nxt = LSI_OFF;
`ifdef RCC_LSI_TMO_EN
      cnt_nxt  = '0;
      fail_nxt = 1'b0;
`endif
    end else begin
      case (state_q)
        LSI_OFF: begin
          state_nxt = LSI_WAIT;
`ifdef RCC_LSI_TMO_EN
          cnt_nxt = '0;
`endif
        end
        LSI_WAIT: begin
          if (rdy_s) begin
            state_nxt = LSI_READY;
          end else begin
`ifdef RCC_LSI_TMO_EN
            if (cnt_q == CNT_LAST) begin
              state_nxt = LSI_FAIL;
              fail_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_q + 1'b1;
            end
`endif
          end
        end
        LSI_READY: begin
          if (!rdy_s) begin
            state_nxt = LSI_WAIT;
`ifdef RCC_LSI_TMO_EN
            cnt_nxt = '0;
`endif
          end
        end
        LSI_FAIL: begin
          if (rdy_s) begin
            state_nxt = LSI_READY;
          end
        end
        default: state_nxt = LSI_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_rcc_rsr_lsi_ctrl.sv
// Testbench for rcc_rsr_lsi_ctrl (default parameters). Build with RCC_LSI_TMO_EN
// defined to also exercise the LSI timeout.
module tb_rcc_rsr_lsi_ctrl;

  localparam int NUM_CPU = 2;
  localparam int NUM_SRC = 14;
  localparam int LSI_TMO = 64;
  localparam logic [13:0] FLAG_INIT = 14'h003E;
`ifdef RCC_LSI_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        pwr_por_rst = 1'b1;
  logic        wdata = 1'b0;
  logic [1:0]  rmvf_wren = '0;
  logic        lsion_wren = 1'b0;
  logic [13:0] rst_src = '0;
  logic        lsi_rdy = 1'b0;
  logic [27:0] cur_rsr_flags;
  logic [1:0]  cur_rsr_rmvf;
  logic        cur_csr_lsion;
  logic        cur_csr_lsirdy;
  logic        lsi_en;
  logic        fail_obs;
`ifdef RCC_LSI_TMO_EN
  logic        lsi_fail;
  assign fail_obs = lsi_fail;
`else
  assign fail_obs = 1'b0;
`endif

  int n_pass = 0;
  int n_total = 0;

  rcc_rsr_lsi_ctrl #(
    .NUM_CPU(NUM_CPU),
    .NUM_SRC(NUM_SRC),
    .RST_FLAG_INIT(FLAG_INIT),
    .LSI_TMO(LSI_TMO)
  ) dut (
    .clk(clk),
    .pwr_por_rst(pwr_por_rst),
    .wdata(wdata),
    .rmvf_wren(rmvf_wren),
    .lsion_wren(lsion_wren),
    .rst_src(rst_src),
    .lsi_rdy(lsi_rdy),
    .cur_rsr_flags(cur_rsr_flags),
    .cur_rsr_rmvf(cur_rsr_rmvf),
    .cur_csr_lsion(cur_csr_lsion),
    .cur_csr_lsirdy(cur_csr_lsirdy),
    .lsi_en(lsi_en)
`ifdef RCC_LSI_TMO_EN
    ,
    .lsi_fail(lsi_fail)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Flags: a 0->1 change of a source seen at sampling edges e-3/e-2 sets the flag
  // at edge e unless that CPU's RMVF bit is already 1. LSI: tracked as booleans.
  logic [13:0] m_flags [NUM_CPU];
  logic [1:0]  m_rmvf = '0;
  bit          m_lsion = 0;
  bit          m_on = 0, m_ready = 0, m_in_fail = 0, m_fail = 0;
  int          m_waited = 0;
  logic [13:0] src_hist [$];
  bit          rdy_hist [$];

  initial begin
    m_flags[0] = FLAG_INIT;
    m_flags[1] = FLAG_INIT;
    src_hist = '{14'h0, 14'h0, 14'h0};
    rdy_hist = '{1'b0, 1'b0, 1'b0};
  end

  always @(posedge clk or posedge pwr_por_rst) begin
    logic [13:0] rise;
    bit rs;
    if (pwr_por_rst) begin
      for (int c = 0; c < NUM_CPU; c++) m_flags[c] = FLAG_INIT;
      m_rmvf = '0;
      m_lsion = 0;
      m_on = 0; m_ready = 0; m_in_fail = 0; m_fail = 0; m_waited = 0;
      src_hist = '{14'h0, 14'h0, 14'h0};
      rdy_hist = '{1'b0, 1'b0, 1'b0};
    end else begin
      rise = src_hist[1] & ~src_hist[2];
      rs = rdy_hist[1];
      for (int c = 0; c < NUM_CPU; c++) begin
        if (m_rmvf[c]) m_flags[c] = '0;
        else m_flags[c] = m_flags[c] | rise;
      end
      if (!m_lsion) begin
        m_on = 0; m_ready = 0; m_in_fail = 0; m_fail = 0;
      end else if (!m_on) begin
        m_on = 1; m_waited = 0;
      end else if (rs) begin
        m_ready = 1; m_in_fail = 0;
      end else if (m_ready) begin
        m_ready = 0; m_waited = 0;
      end else if (!m_in_fail) begin
        if (TMO_EN && m_waited == LSI_TMO - 1) begin
          m_in_fail = 1; m_fail = 1;
        end else begin
          m_waited++;
        end
      end
      for (int c = 0; c < NUM_CPU; c++) if (rmvf_wren[c]) m_rmvf[c] = wdata;
      if (lsion_wren) m_lsion = wdata;
      src_hist.push_front(rst_src);
      void'(src_hist.pop_back());
      rdy_hist.push_front(lsi_rdy);
      void'(rdy_hist.pop_back());
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wdata = 1'b0;
    rmvf_wren = '0;
    lsion_wren = 1'b0;
    rst_src = '0;
  endtask

  typedef struct {
    logic [1:0]  wren;
    logic        wd;
    logic [13:0] src;
    logic [13:0] exp_f1;
    logic [13:0] exp_f0;
    logic [1:0]  exp_rmvf;
  } vec_t;

  vec_t vecs [20];

  initial begin
    vecs[0]  = '{2'b01, 1'b1, 14'h0000, 14'h003E, 14'h003E, 2'b01};
    vecs[1]  = '{2'b00, 1'b0, 14'h0000, 14'h003E, 14'h0000, 2'b01};
    vecs[2]  = '{2'b01, 1'b0, 14'h0000, 14'h003E, 14'h0000, 2'b00};
    vecs[3]  = '{2'b00, 1'b0, 14'h0100, 14'h003E, 14'h0000, 2'b00};
    vecs[4]  = '{2'b00, 1'b0, 14'h0000, 14'h003E, 14'h0000, 2'b00};
    vecs[5]  = '{2'b00, 1'b0, 14'h0000, 14'h013E, 14'h0100, 2'b00};
    vecs[6]  = '{2'b10, 1'b1, 14'h0000, 14'h013E, 14'h0100, 2'b10};
    vecs[7]  = '{2'b00, 1'b0, 14'h2000, 14'h0000, 14'h0100, 2'b10};
    vecs[8]  = '{2'b00, 1'b0, 14'h0000, 14'h0000, 14'h0100, 2'b10};
    vecs[9]  = '{2'b00, 1'b0, 14'h0000, 14'h0000, 14'h2100, 2'b10};
    vecs[10] = '{2'b00, 1'b0, 14'h2000, 14'h0000, 14'h2100, 2'b10};
    vecs[11] = '{2'b00, 1'b0, 14'h2000, 14'h0000, 14'h2100, 2'b10};
    vecs[12] = '{2'b00, 1'b0, 14'h2000, 14'h0000, 14'h2100, 2'b10};
    vecs[13] = '{2'b10, 1'b0, 14'h2000, 14'h0000, 14'h2100, 2'b00};
    vecs[14] = '{2'b00, 1'b0, 14'h2000, 14'h0000, 14'h2100, 2'b00};
    vecs[15] = '{2'b00, 1'b0, 14'h0401, 14'h0000, 14'h2100, 2'b00};
    vecs[16] = '{2'b00, 1'b0, 14'h0000, 14'h0000, 14'h2100, 2'b00};
    vecs[17] = '{2'b00, 1'b0, 14'h0000, 14'h0401, 14'h2501, 2'b00};
    vecs[18] = '{2'b01, 1'b1, 14'h0000, 14'h0401, 14'h2501, 2'b01};
    vecs[19] = '{2'b00, 1'b0, 14'h0000, 14'h0401, 14'h0000, 2'b01};

    // reset state
    repeat (3) @(posedge clk);
    #1 pwr_por_rst = 1'b0;
    check("reset_flags", cur_rsr_flags, {FLAG_INIT, FLAG_INIT});
    check("reset_rmvf", cur_rsr_rmvf, 2'b00);
    check("reset_lsion", cur_csr_lsion, 1'b0);
    check("reset_lsirdy", cur_csr_lsirdy, 1'b0);
    check("reset_lsi_en", lsi_en, 1'b0);
    check("reset_lsi_fail", fail_obs, 1'b0);

    // table: capture latency, RMVF clear/dominance/release, multi-source edges
    for (int i = 0; i < 20; i++) begin
      rmvf_wren = vecs[i].wren;
      wdata     = vecs[i].wd;
      rst_src   = vecs[i].src;
      tick();
      check($sformatf("vec%0d_flags", i), cur_rsr_flags, {vecs[i].exp_f1, vecs[i].exp_f0});
      check($sformatf("vec%0d_rmvf", i), cur_rsr_rmvf, vecs[i].exp_rmvf);
    end
    idle_inputs();

    // LSI enable / ready handshake
    lsion_wren = 1'b1; wdata = 1'b1;
    tick();
    idle_inputs();
    check("lsion_set", cur_csr_lsion, 1'b1);
    check("lsi_en_not_yet", lsi_en, 1'b0);
    tick();
    check("lsi_en_wait", lsi_en, 1'b1);
    check("lsirdy_wait", cur_csr_lsirdy, 1'b0);
    repeat (9) tick();
    lsi_rdy = 1'b1;
    tick(); tick();
    check("lsirdy_2_edges", cur_csr_lsirdy, 1'b0);
    tick();
    check("lsirdy_3_edges", cur_csr_lsirdy, 1'b1);
    check("lsi_en_ready", lsi_en, 1'b1);
    lsi_rdy = 1'b0;
    tick(); tick();
    check("lsirdy_drop_2_edges", cur_csr_lsirdy, 1'b1);
    tick();
    check("lsirdy_drop_3_edges", cur_csr_lsirdy, 1'b0);
    check("lsi_en_back_wait", lsi_en, 1'b1);
    lsion_wren = 1'b1; wdata = 1'b0;
    tick();
    idle_inputs();
    check("lsion_clear", cur_csr_lsion, 1'b0);
    tick();
    check("lsi_en_off", lsi_en, 1'b0);
    check("lsirdy_off", cur_csr_lsirdy, 1'b0);

`ifdef RCC_LSI_TMO_EN
    // LSI timeout: lsi_fail exactly LSI_TMO cycles after WAIT entry
    lsion_wren = 1'b1; wdata = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("tmo_wait_entry_en", lsi_en, 1'b1);
    repeat (LSI_TMO - 1) tick();
    check("tmo_fail_not_yet", lsi_fail, 1'b0);
    tick();
    check("tmo_fail_set", lsi_fail, 1'b1);
    check("tmo_fail_en", lsi_en, 1'b1);
    check("tmo_fail_lsirdy", cur_csr_lsirdy, 1'b0);
    lsi_rdy = 1'b1;
    repeat (3) tick();
    check("tmo_late_ready", cur_csr_lsirdy, 1'b1);
    check("tmo_fail_sticky", lsi_fail, 1'b1);
    lsion_wren = 1'b1; wdata = 1'b0;
    tick();
    idle_inputs();
    tick();
    check("tmo_off_en", lsi_en, 1'b0);
    check("tmo_off_lsirdy", cur_csr_lsirdy, 1'b0);
    check("tmo_off_fail", lsi_fail, 1'b0);
    lsi_rdy = 1'b0;
`endif

    // asynchronous reset in the middle of WAIT with all flags cleared
    rmvf_wren = 2'b11; wdata = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("pre_rst_flags_zero", cur_rsr_flags, 28'h0);
    lsion_wren = 1'b1; wdata = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();
    check("pre_rst_wait_en", lsi_en, 1'b1);
    #2 pwr_por_rst = 1'b1;
    #1;
    check("async_rst_flags", cur_rsr_flags, {FLAG_INIT, FLAG_INIT});
    check("async_rst_rmvf", cur_rsr_rmvf, 2'b00);
    check("async_rst_lsion", cur_csr_lsion, 1'b0);
    check("async_rst_lsirdy", cur_csr_lsirdy, 1'b0);
    check("async_rst_lsi_en", lsi_en, 1'b0);
    check("async_rst_lsi_fail", fail_obs, 1'b0);
    tick(); tick();
    pwr_por_rst = 1'b0;

    // randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      rst_src    = 14'($urandom & $urandom & $urandom);
      wdata      = 1'($urandom);
      rmvf_wren  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      lsion_wren = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 29) == 0) lsi_rdy = ~lsi_rdy;
      tick();
      check("rand_flags", cur_rsr_flags, {m_flags[1], m_flags[0]});
      check("rand_rmvf", cur_rsr_rmvf, m_rmvf);
      check("rand_lsion", cur_csr_lsion, m_lsion);
      check("rand_lsirdy", cur_csr_lsirdy, m_ready);
      check("rand_lsi_en", lsi_en, m_on);
      check("rand_lsi_fail", fail_obs, m_fail);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
